// File: rtl/tx232_ser.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tx232_ser
// Asynchronous-serial transmitter that sits directly after the TX byte
// sequencer. A rising edge on tstart captures txpd into a one-deep holding
// register. The frame engine then sends one frame per held byte: a start bit
// (0), DW data bits LSB first, and STOP_BITS stop bits (1). Each bit lasts one
// txck period. txck is a slow bit-rate strobe and is edge-detected in the clk
// domain; everything runs on clk.
//
// Optional feature macro: TX232_OVR_EN
//   defined   : adds the sticky overrun flag ovr and its clear input ovr_clr
//   undefined : neither port exists; a pending byte is still overwritten
//
// Ports
//   clk      in   1   system clock
//   rst      in   1   asynchronous reset, active low
//   txck     in   1   bit-rate clock, sampled on clk
//   tstart   in   1   frame request (level); its rising edge loads txpd
//   txpd     in   DW  byte to send, valid when tstart rises
//   txd      out  1   serial line, idle high
//   busy     out  1   high from the start-bit edge until the last stop bit ends
//   done     out  1   one-clk pulse when a frame's last stop bit completes
//   ovr      out  1   sticky overrun flag              (TX232_OVR_EN only)
//   ovr_clr  in   1   synchronous clear of ovr         (TX232_OVR_EN only)
//
// Handshake: there is no ready back to the sequencer. A tstart edge always
// writes the holding register; the engine consumes it at a bit boundary.
// A second edge before consumption replaces the pending byte.
// -----------------------------------------------------------------------------
module tx232_ser #(
  parameter int DW        = 8,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          txck,
  input  logic          tstart,
  input  logic [DW-1:0] txpd,
  output logic          txd,
  output logic          busy,
  output logic          done
`ifdef TX232_OVR_EN
  ,
  output logic          ovr,
  input  logic          ovr_clr
`endif
);

  localparam int CW = $clog2(DW + STOP_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // state is left as a named signal so checkers can bind to it directly
  state_t          state, state_nx;

  logic            tc0, tc1, st0, st1;
  logic            tcenr, ld;
  logic [DW-1:0]   hold, hold_nx;
  logic            hold_vld, hold_vld_nx;
  logic [DW-1:0]   sh, sh_nx;
  logic [CW-1:0]   bcnt, bcnt_nx;
  logic            txd_nx, busy_nx, done_nx;
  logic            consume;
`ifdef TX232_OVR_EN
  logic            ovr_nx;
`endif

  // One-clk pulses on the rising edges of txck and tstart
  assign tcenr = tc0 & ~tc1;
  assign ld    = st0 & ~st1;

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    bcnt_nx  = bcnt;
    txd_nx   = txd;
    busy_nx  = busy;
    done_nx  = 1'b0;
    consume  = 1'b0;

    if (tcenr) begin
      case (state)
        IDLE: begin
          txd_nx  = 1'b1;
          busy_nx = 1'b0;
          if (hold_vld) begin
            consume  = 1'b1;
            sh_nx    = hold;
            txd_nx   = 1'b0;
            busy_nx  = 1'b1;
            state_nx = START;
          end
        end
        START: begin
          txd_nx   = sh[0];
          sh_nx    = sh >> 1;
          bcnt_nx  = '0;
          state_nx = DATA;
        end
        DATA: begin
          if (bcnt != CW'(DW - 1)) begin
            txd_nx  = sh[0];
            sh_nx   = sh >> 1;
            bcnt_nx = bcnt + CW'(1);
          end else begin
            txd_nx   = 1'b1;
            bcnt_nx  = '0;
            state_nx = STOP;
          end
        end
        STOP: begin
          if (bcnt != CW'(STOP_BITS - 1)) begin
            bcnt_nx = bcnt + CW'(1);
          end else begin
            done_nx = 1'b1;
            if (hold_vld) begin
              // Chain straight into the next start bit: no idle gap
              consume  = 1'b1;
              sh_nx    = hold;
              txd_nx   = 1'b0;
              state_nx = START;
            end else begin
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end
          end
        end
        default: begin
          txd_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      endcase
    end

    // A load in the same clk as a consume: the engine takes the old byte
    // (registered hold) and the new byte stays pending.
    hold_nx     = ld ? txpd : hold;
    hold_vld_nx = ld ? 1'b1 : (consume ? 1'b0 : hold_vld);

`ifdef TX232_OVR_EN
    // Set wins over a simultaneous clear
    if (ld && hold_vld && !consume) ovr_nx = 1'b1;
    else if (ovr_clr)               ovr_nx = 1'b0;
    else                            ovr_nx = ovr;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tc0      <= 1'b0;
      tc1      <= 1'b0;
      st0      <= 1'b0;
      st1      <= 1'b0;
      hold     <= '0;
      hold_vld <= 1'b0;
      sh       <= '0;
      bcnt     <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      tc0      <= txck;
      tc1      <= tc0;
      st0      <= tstart;
      st1      <= st0;
      hold     <= hold_nx;
      hold_vld <= hold_vld_nx;
      sh       <= sh_nx;
      bcnt     <= bcnt_nx;
      txd      <= txd_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

`ifdef TX232_OVR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovr <= 1'b0;
    else      ovr <= ovr_nx;
  end
`endif

endmodule

// File: tb/tb_tx232_ser.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tx232_ser
// Directed bench for tx232_ser. u_dut uses STOP_BITS=1 and is watched by a
// bit monitor that samples txd in the middle of each txck period (txck falling
// edge) and compares against the expected bit queue filled by send_byte.
// u_dut2 uses STOP_BITS=2 and is checked inline.
// -----------------------------------------------------------------------------
module tb_tx232_ser;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txck = 1'b0;
  int         tcnt = 0;

  always #5 clk = ~clk;

  // txck = clk/16, changed on clk falling edges so the DUT samples it cleanly
  always @(negedge clk) begin
    tcnt = tcnt + 1;
    if (tcnt == 8) begin
      tcnt = 0;
      txck = ~txck;
    end
  end

  // ---------------- DUT signals ----------------
  logic       tstart = 1'b0;
  logic [7:0] txpd = 8'h00;
  logic       txd, busy, done;
  logic       tstart2 = 1'b0;
  logic [7:0] txpd2 = 8'h00;
  logic       txd2, busy2, done2;
`ifdef TX232_OVR_EN
  logic       ovr, ovr2;
  logic       ovr_clr = 1'b0;
`endif

  tx232_ser #(.DW(8), .STOP_BITS(1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .txck   (txck),
    .tstart (tstart),
    .txpd   (txpd),
    .txd    (txd),
    .busy   (busy),
    .done   (done)
`ifdef TX232_OVR_EN
    ,
    .ovr    (ovr),
    .ovr_clr(ovr_clr)
`endif
  );

  tx232_ser #(.DW(8), .STOP_BITS(2)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .txck   (txck),
    .tstart (tstart2),
    .txpd   (txpd2),
    .txd    (txd2),
    .busy   (busy2),
    .done   (done2)
`ifdef TX232_OVR_EN
    ,
    .ovr    (ovr2),
    .ovr_clr(ovr_clr)
`endif
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event counters for done pulses and busy falling edges
  int   done_cnt   = 0;
  int   done2_cnt  = 0;
  int   busy_falls = 0;
  logic busy_q     = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1)  done_cnt++;
    if (done2 === 1'b1) done2_cnt++;
    if (busy_q === 1'b1 && busy === 1'b0) busy_falls++;
    busy_q = busy;
  end

  // Bit monitor for u_dut: a 0 outside a frame is a start bit, then
  // 9 more samples (8 data + 1 stop) belong to the same frame.
  logic mon_en   = 1'b0;
  logic in_frame = 1'b0;
  int   bit_idx  = 0;

  task automatic pop_check();
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      chkn("queue_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk1("txd_bit", txd, e[0]);
      chk1("busy_in_frame", busy, 1'b1);
    end
  endtask

  always @(negedge txck) begin
    if (!mon_en) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        in_frame = 1'b1;
        bit_idx  = 1;
        pop_check();
      end
    end else begin
      pop_check();
      bit_idx++;
      if (bit_idx == 10) in_frame = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Expected frame: start 0, data LSB first, one stop 1
  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic push);
    @(negedge clk);
    txpd = b;
    if (push) push_frame(b);
    tstart = 1'b1;
    repeat (4) @(negedge clk);
    tstart = 1'b0;
  endtask

  task automatic wait_periods(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int d0, b0, k;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_txd2", txd2, 1'b1);
`ifdef TX232_OVR_EN
    chk1("rst_ovr", ovr, 1'b0);
`endif
    rst = 1'b1;
    wait_periods(2);
    mon_en = 1'b1;

    // 1: single frame 8'hA5
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    wait_periods(13);
    chkn("t1_q_empty", exp_q.size(), 0);
    chkn("t1_done", done_cnt - d0, 1);
    chk1("t1_idle_txd", txd, 1'b1);
    chk1("t1_idle_busy", busy, 1'b0);

    // 2: sequencer-style burst, one byte every 10 txck periods
    d0 = done_cnt;
    b0 = busy_falls;
    foreach (txpd[i]) begin end
    send_byte(8'h01, 1'b1);
    repeat (160 - 5) @(negedge clk);
    send_byte(8'h02, 1'b1);
    repeat (160 - 5) @(negedge clk);
    send_byte(8'h04, 1'b1);
    repeat (160 - 5) @(negedge clk);
    send_byte(8'h80, 1'b1);
    wait_periods(14);
    chkn("t2_q_empty", exp_q.size(), 0);
    chkn("t2_done", done_cnt - d0, 4);
    chkn("t2_busy_falls", busy_falls - b0, 1);

    // 3: tstart held high for 30 periods -> one frame only
    d0 = done_cnt;
    @(negedge clk);
    txpd = 8'h3C;
    push_frame(8'h3C);
    tstart = 1'b1;
    wait_periods(30);
    tstart = 1'b0;
    wait_periods(3);
    chkn("t3_q_empty", exp_q.size(), 0);
    chkn("t3_done", done_cnt - d0, 1);
    chk1("t3_txd", txd, 1'b1);
    chk1("t3_busy", busy, 1'b0);

    // 4: second and third edges inside one frame; 8'h22 is overwritten
    d0 = done_cnt;
    send_byte(8'h11, 1'b1);
    wait_periods(3);
    send_byte(8'h22, 1'b0);
    wait_periods(2);
    send_byte(8'h33, 1'b1);
    wait_periods(24);
    chkn("t4_q_empty", exp_q.size(), 0);
    chkn("t4_done", done_cnt - d0, 2);
`ifdef TX232_OVR_EN
    chk1("t4_ovr_set", ovr, 1'b1);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk1("t4_ovr_clr", ovr, 1'b0);
`endif

    // 5: reset in the middle of an 8'hFF frame
    mon_en = 1'b0;
    d0 = done_cnt;
    send_byte(8'hFF, 1'b0);
    k = 0;
    do begin
      @(negedge txck);
      k++;
    end while (txd !== 1'b0 && k < 40);
    chk1("t5_start", txd, 1'b0);
    repeat (5) @(negedge txck);   // now mid data bit 4
    chk1("t5_bit4", txd, 1'b1);
    chk1("t5_busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t5_rst_txd", txd, 1'b1);
    chk1("t5_rst_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    wait_periods(14);
    chkn("t5_no_done", done_cnt - d0, 0);
    chk1("t5_idle_txd", txd, 1'b1);
    chk1("t5_idle_busy", busy, 1'b0);
    mon_en = 1'b1;
    d0 = done_cnt;
    send_byte(8'h5A, 1'b1);
    wait_periods(13);
    chkn("t5_q_empty", exp_q.size(), 0);
    chkn("t5_done_after", done_cnt - d0, 1);

    // 6: two stop bits on u_dut2, 8'h00
    d0 = done2_cnt;
    @(negedge clk);
    txpd2 = 8'h00;
    tstart2 = 1'b1;
    repeat (4) @(negedge clk);
    tstart2 = 1'b0;
    k = 0;
    do begin
      @(negedge txck);
      k++;
    end while (txd2 !== 1'b0 && k < 40);
    chk1("t6_start", txd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge txck);
      chk1("t6_data", txd2, 1'b0);
    end
    @(negedge txck);
    chk1("t6_stop1", txd2, 1'b1);
    chk1("t6_stop1_busy", busy2, 1'b1);
    @(negedge txck);
    chk1("t6_stop2", txd2, 1'b1);
    chk1("t6_stop2_busy", busy2, 1'b1);
    chkn("t6_no_done_yet", done2_cnt - d0, 0);
    @(negedge txck);
    chkn("t6_done", done2_cnt - d0, 1);
    chk1("t6_idle_txd", txd2, 1'b1);
    chk1("t6_idle_busy", busy2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
